// File: rtl/banco_reg_wb.sv
// banco_reg_wb: MIPS multicycle GPR file, write-back mux and A/B operand latch.
// Ports: clock/reset (async, active-high); EscreveReg, RegDst and MemparaReg
//   control the write; rs/rt/rd/imm are instruction fields; alu_out and mdr
//   are write-back sources; A/B are the registered operands; dbg_addr and
//   dbg_data form a combinational debug read port.
// Optional: define REGFILE_BYPASS_EN to forward same-edge write data to A/B.
module banco_reg_wb #(
    parameter int          NREGS    = 32,
    parameter int          SP_INDEX = 29,
    parameter logic [31:0] SP_RESET = 32'd227
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        EscreveReg,
    input  logic        RegDst,
    input  logic [1:0]  MemparaReg,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [31:0] alu_out,
    input  logic [31:0] mdr,
    output logic [31:0] A,
    output logic [31:0] B,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    logic [31:0] regs [NREGS];
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wsel_ok;
    logic        wr_en;
    logic [31:0] a_next;
    logic [31:0] b_next;

    // Addresses beyond NREGS (smaller builds) read as zero.
    function automatic logic [31:0] rd_reg(input logic [4:0] addr);
        logic [31:0] v;
        v = '0;
        if (addr != 5'd0 && int'(addr) < NREGS)
            v = regs[addr];
        return v;
    endfunction

    assign waddr = RegDst ? rd : rt;

    always_comb begin
        wdata   = '0;
        wsel_ok = 1'b1;
        unique case (MemparaReg)
            2'b00:   wdata = alu_out;
            2'b01:   wdata = mdr;
            2'b10:   wdata = {imm, 16'h0000};
            default: wsel_ok = 1'b0;
        endcase
    end

    // Register 0 is hardwired: writes to it are simply never enabled.
    assign wr_en = EscreveReg && wsel_ok && (waddr != 5'd0)
                   && (int'(waddr) < NREGS);

    always_comb begin
        a_next = rd_reg(rs);
        b_next = rd_reg(rt);
`ifdef REGFILE_BYPASS_EN
        if (wr_en && rs == waddr)
            a_next = wdata;
        if (wr_en && rt == waddr)
            b_next = wdata;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= (i == SP_INDEX) ? SP_RESET : 32'd0;
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            A <= '0;
            B <= '0;
        end else begin
            A <= a_next;
            B <= b_next;
        end
    end

    assign dbg_data = rd_reg(dbg_addr);

endmodule

// File: tb/tb_banco_reg_wb.sv
// tb_banco_reg_wb: directed plus random checks of banco_reg_wb against
// an array-based reference model of the register file.
module tb_banco_reg_wb;

    logic        clock = 1'b0;
    logic        reset;
    logic        EscreveReg;
    logic        RegDst;
    logic [1:0]  MemparaReg;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] alu_out, mdr;
    logic [31:0] A, B;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int total = 0;
    int bad   = 0;
    logic [31:0] mreg [32];

    banco_reg_wb dut (
        .clock(clock), .reset(reset), .EscreveReg(EscreveReg),
        .RegDst(RegDst), .MemparaReg(MemparaReg), .rs(rs), .rt(rt),
        .rd(rd), .imm(imm), .alu_out(alu_out), .mdr(mdr), .A(A), .B(B),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        mreg[29] = 32'd227;
    endtask

    // One clock: predict from the current inputs, take the edge, compare.
    task automatic step();
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        we;
        logic [31:0] ea, eb;
        wa = RegDst ? rd : rt;
        case (MemparaReg)
            2'd0:    wd = alu_out;
            2'd1:    wd = mdr;
            2'd2:    wd = {imm, 16'h0000};
            default: wd = 32'd0;
        endcase
        we = EscreveReg && wa != 5'd0 && MemparaReg != 2'd3;
        ea = mreg[rs];
        eb = mreg[rt];
`ifdef REGFILE_BYPASS_EN
        if (we && rs == wa) ea = wd;
        if (we && rt == wa) eb = wd;
`endif
        @(posedge clock);
        #1;
        if (we) mreg[wa] = wd;
        chk("A", A, ea);
        chk("B", B, eb);
        chk("dbg", dbg_data, mreg[dbg_addr]);
        @(negedge clock);
    endtask

    task automatic idle();
        EscreveReg = 1'b0; RegDst = 1'b0; MemparaReg = 2'd0;
        rs = 5'd0; rt = 5'd0; rd = 5'd0; imm = 16'd0;
        alu_out = 32'd0; mdr = 32'd0;
    endtask

    task automatic peek(input string tag, input logic [4:0] a,
                        input logic [31:0] exp);
        dbg_addr = a;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    initial begin
        idle();
        dbg_addr = 5'd0;
        reset = 1'b1;
        model_reset();
        #2;
        chk("rst_A", A, 32'd0);
        chk("rst_B", B, 32'd0);
        peek("rst_sp", 5'd29, 32'd227);
        peek("rst_r5", 5'd5, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // rd=8 <- alu_out
        EscreveReg = 1; RegDst = 1; rd = 8; MemparaReg = 0;
        alu_out = 32'hAB; rt = 3;
        step();
        idle(); rs = 8; rt = 3;
        step();
        chk("A_r8", A, 32'hAB);
        chk("B_r3", B, 32'd0);

        // LUI and mdr sources through rt
        EscreveReg = 1; RegDst = 0; rt = 9; MemparaReg = 2; imm = 16'h1234;
        step();
        MemparaReg = 1; mdr = 32'hDEADBEEF; rt = 10;
        step();
        idle();
        peek("lui_r9", 5'd9, 32'h12340000);
        peek("mdr_r10", 5'd10, 32'hDEADBEEF);

        // Writes to r0 dropped; select 11 suppresses writes
        EscreveReg = 1; RegDst = 1; rd = 0; alu_out = 32'hFFFFFFFF;
        step();
        idle();
        step();
        chk("A_r0", A, 32'd0);
        peek("dbg_r0", 5'd0, 32'd0);
        EscreveReg = 1; RegDst = 1; rd = 8; MemparaReg = 3;
        alu_out = 32'h77; mdr = 32'h66;
        step();
        idle();
        peek("sel11_r8", 5'd8, 32'hAB);

        // Same-edge read of a register being written
        EscreveReg = 1; RegDst = 1; rd = 8; MemparaReg = 0;
        alu_out = 32'h55; rs = 8; rt = 8;
        step();
`ifdef REGFILE_BYPASS_EN
        chk("rdw_A", A, 32'h55);
        chk("rdw_B", B, 32'h55);
`else
        chk("rdw_A", A, 32'hAB);
        chk("rdw_B", B, 32'hAB);
`endif
        idle(); rs = 8; rt = 8;
        step();
        chk("rdw2_A", A, 32'h55);
        chk("rdw2_B", B, 32'h55);

        // Randomized traffic on a small address pool to force collisions
        for (int n = 0; n < 400; n++) begin
            EscreveReg = 1'($urandom_range(0, 3) != 0);
            RegDst     = 1'($urandom);
            MemparaReg = 2'($urandom);
            rs         = 5'($urandom_range(0, 11));
            rt         = 5'($urandom_range(0, 11));
            rd         = 5'($urandom_range(0, 11));
            imm        = 16'($urandom);
            alu_out    = $urandom;
            mdr        = $urandom;
            dbg_addr   = 5'($urandom);
            if (n % 50 == 7) rs = 5'd29;
            step();
        end

        // Reset mid-write, between edges: takes effect immediately
        EscreveReg = 1; RegDst = 1; rd = 8; MemparaReg = 0;
        alu_out = 32'h99; rs = 8; rt = 29;
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        chk("arst_A", A, 32'd0);
        chk("arst_B", B, 32'd0);
        peek("arst_r8", 5'd8, 32'd0);
        peek("arst_sp", 5'd29, 32'd227);
        @(negedge clock);
        peek("arst_hold_r8", 5'd8, 32'd0);
        reset = 1'b0;
        idle(); rs = 8; rt = 29;
        step();
        chk("post_B_sp", B, 32'd227);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/banco_reg_wb.md
Name: banco_reg_wb

Overview:
- Register file and write-back stage of the multicycle MIPS datapath, directly downstream of the control unit.
- Consumes EscreveReg, RegDst and a 2-bit write-data select.
- Holds the 32x32 GPR array and latches the A/B operand registers that feed the ALU.
- Adds the LUI write-back source (imm << 16) that the current write-data mux lacks.

Parameters:
- NREGS, 32: number of GPRs (address width fixed at 5 bits).
- SP_INDEX, 29: index of the stack-pointer register.
- SP_RESET, 32'd227: reset value of the stack-pointer register.

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high.
- EscreveReg  in  1  GPR write enable.
- RegDst  in  1  write address select: 0 = rt, 1 = rd.
- MemparaReg  in  2  write data select: 00 = alu_out, 01 = mdr, 10 = {imm,16'h0}, 11 = reserved.
- rs  in  5  instruction bits [25:21].
- rt  in  5  instruction bits [20:16].
- rd  in  5  instruction bits [15:11].
- imm  in  16  instruction bits [15:0].
- alu_out  in  32  ALUOut register value.
- mdr  in  32  memory data register value.
- A  out  32  registered GPR[rs].
- B  out  32  registered GPR[rt].
- dbg_addr  in  5  debug read address.
- dbg_data  out  32  combinational GPR[dbg_addr].

Behaviour:
- Reset (async, immediate):
  - All GPRs cleared to 0, except GPR[SP_INDEX], which loads SP_RESET.
  - A = 0 and B = 0.
  - Reset asserted in the same cycle as a write: reset wins and the write is lost.
- Write address:
  - waddr = RegDst ? rd : rt.
- Write data:
  - MemparaReg 00 selects alu_out.
  - MemparaReg 01 selects mdr.
  - MemparaReg 10 selects {imm, 16'h0000}.
  - MemparaReg 11: write suppressed even when EscreveReg = 1; no GPR changes.
- Write:
  - On posedge, when EscreveReg = 1 and waddr != 0, GPR[waddr] <= wdata.
  - Writes to GPR[0] are dropped; GPR[0] always reads 0.
- Operand latch:
  - Every posedge, with no enable: A <= GPR[rs] and B <= GPR[rt].
  - A/B always reflect the GPR contents sampled one cycle earlier.
  - Latency from a write edge to visibility on A/B is one further edge (default build).
- Read-during-write at the same edge, rs or rt == waddr:
  - A/B capture the OLD value (default build).
  - The new value appears on A/B at the next edge.
- Debug port:
  - dbg_data = GPR[dbg_addr], combinational; dbg_addr = 0 gives 0.
  - After a write edge, dbg_data shows the new value in the same cycle.
- rs == rt: A and B receive identical values.
- Storage is edge-triggered flops; no latches.
- Register array is flop-based (no memory inference requirement); asynchronous reset on every element.

Optional Feature:
- REGFILE_BYPASS_EN defined: at an edge where a write occurs (EscreveReg = 1, waddr != 0, MemparaReg != 11) and rs == waddr (resp. rt == waddr), A (resp. B) captures wdata instead of the old GPR value. Zero-latency write-to-operand forwarding; waddr == 0 is never forwarded.
- REGFILE_BYPASS_EN undefined: old-value semantics as in Behaviour.

Test Plan:
- Reset, then dbg_addr = 29 -> dbg_data = 227. dbg_addr = 5 -> 0. A = B = 0.
- EscreveReg = 1, RegDst = 1, rd = 8, MemparaReg = 00, alu_out = 32'h0000_00AB; next cycle rs = 8 -> after the following edge A = 32'hAB, and GPR[rt] unchanged.
- RegDst = 0, rt = 9, MemparaReg = 10, imm = 16'h1234 -> GPR[9] = 32'h1234_0000. MemparaReg = 01, mdr = 32'hDEAD_BEEF, rt = 10 -> GPR[10] = 32'hDEAD_BEEF.
- Write rd = 0 with alu_out = 32'hFFFF_FFFF -> dbg_data(0) = 0, A(rs = 0) = 0. MemparaReg = 11 with EscreveReg = 1, rd = 8 -> GPR[8] keeps 32'hAB.
- Same-edge write GPR[8] = 32'h55 with rs = rt = 8 -> A = B = old 32'hAB without REGFILE_BYPASS_EN, 32'h55 with it. Both are 32'h55 one edge later.
- Assert reset mid-write (EscreveReg = 1, rd = 8) between edges -> GPR[8] = 0, GPR[29] = 227, and A/B = 0 immediately, before the next edge.
